// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// load_store_unit : byte-addressed load/store front end for a 1-cycle BRAM
// Revision 1.0
// ============================================================================
module load_store_unit #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [3:0]  mem_wea,
  output logic [31:0] mem_addra,
  output logic [31:0] mem_dina,
  input  logic [31:0] mem_douta
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WR   = 3'd1;
  localparam logic [2:0] S_RD0  = 3'd2;
  localparam logic [2:0] S_RD1  = 3'd3;
  localparam logic [2:0] S_RESP = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [1:0]  size_q, lane_q;
  logic        signed_q;
  logic [3:0]  wea_q, wea_d;
  logic [31:0] addra_q, addra_d;
  logic [31:0] dina_q, dina_d;
  logic        rvalid_q, rvalid_d;
  logic        rerr_q, rerr_d;
  logic [31:0] rdata_q, rdata_d;
  logic        req_err;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  assign req_ready  = (state_q == S_IDLE);
  assign resp_valid = rvalid_q;
  assign resp_err   = rerr_q;
  assign resp_rdata = rdata_q;
  assign mem_wea    = wea_q;
  assign mem_addra  = addra_q;
  assign mem_dina   = dina_q;

  // Misaligned, reserved-size or beyond-the-RAM accesses never touch memory.
  assign req_err = (req_size == 2'b11)
                || ((req_size == 2'b01) && req_addr[0])
                || ((req_size == 2'b10) && (req_addr[1:0] != 2'b00))
                || ((req_addr >> (ADDR_W + 2)) != 32'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      wea_q    <= 4'b0;
      addra_q  <= 32'd0;
      dina_q   <= 32'd0;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      wea_q    <= wea_d;
      addra_q  <= addra_d;
      dina_q   <= dina_d;
      rvalid_q <= rvalid_d;
      rerr_q   <= rerr_d;
      rdata_q  <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      size_q   <= 2'b00;
      lane_q   <= 2'b00;
      signed_q <= 1'b0;
    end else if (req_valid && req_ready) begin
      size_q   <= req_size;
      lane_q   <= req_addr[1:0];
      signed_q <= req_signed;
    end
  end

  always_comb begin
    state_d = S_IDLE;
    case (state_q)
      S_IDLE: begin
        if (!req_valid)   state_d = S_IDLE;
        else if (req_err) state_d = S_RESP;
        else if (req_we)  state_d = S_WR;
        else              state_d = S_RD0;
      end
      S_WR:    state_d = S_RESP;
      S_RD0:   state_d = S_RD1;
      S_RD1:   state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    ld_byte = 8'd0;
    case (lane_q)
      2'd0:    ld_byte = mem_douta[7:0];
      2'd1:    ld_byte = mem_douta[15:8];
      2'd2:    ld_byte = mem_douta[23:16];
      default: ld_byte = mem_douta[31:24];
    endcase
    ld_half = lane_q[1] ? mem_douta[31:16] : mem_douta[15:0];
    case (size_q)
      2'b00:   ld_data = {{24{signed_q & ld_byte[7]}}, ld_byte};
      2'b01:   ld_data = {{16{signed_q & ld_half[15]}}, ld_half};
      default: ld_data = mem_douta;
    endcase
  end

  // Output registers are loaded with the value they must show in the next state.
  always_comb begin
    wea_d    = 4'b0;
    addra_d  = addra_q;
    dina_d   = dina_q;
    rvalid_d = 1'b0;
    rerr_d   = 1'b0;
    rdata_d  = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && req_err) begin
          rvalid_d = 1'b1;
          rerr_d   = 1'b1;
        end else if (req_valid) begin
          addra_d = {{(32 - ADDR_W){1'b0}}, req_addr[ADDR_W+1:2]};
          if (req_we) begin
            case (req_size)
              2'b00: begin
                wea_d  = 4'b0001 << req_addr[1:0];
                dina_d = {4{req_wdata[7:0]}};
              end
              2'b01: begin
                wea_d  = req_addr[1] ? 4'b1100 : 4'b0011;
                dina_d = {2{req_wdata[15:0]}};
              end
              default: begin
                wea_d  = 4'b1111;
                dina_d = req_wdata;
              end
            endcase
          end
        end
      end
      S_WR: rvalid_d = 1'b1;
      S_RD1: begin
        rvalid_d = 1'b1;
        rdata_d  = ld_data;
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// tb_load_store_unit : directed + random checks against a byte-array model
// Revision 1.0
// ============================================================================
module tb_load_store_unit;

  localparam int AW = 10;
  localparam int MEM_BYTES = 4 * (1 << AW);

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [3:0]  mem_wea;
  logic [31:0] mem_addra;
  logic [31:0] mem_dina;
  logic [31:0] mem_douta;

  int n_total = 0;
  int n_bad = 0;

  logic [31:0] ram [0:(1<<AW)-1];
  logic [7:0]  ref_mem [0:MEM_BYTES-1];
  logic [31:0] last_rdata;

  load_store_unit #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .mem_wea(mem_wea), .mem_addra(mem_addra),
    .mem_dina(mem_dina), .mem_douta(mem_douta)
  );

  always #5 clk = ~clk;

  // Block RAM stand-in: byte write enables, one-cycle registered read.
  always @(posedge clk) begin
    for (int k = 0; k < 4; k++)
      if (mem_wea[k]) ram[mem_addra[AW-1:0]][8*k +: 8] <= mem_dina[8*k +: 8];
    mem_douta <= ram[mem_addra[AW-1:0]];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
    int n;
    logic [31:0] v;
    n = nbytes(sz);
    v = 32'd0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_mem[a + i]) << (8 * i));
    if (sg && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
    return v;
  endfunction

  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
    int n, lat, wcnt, exp_lat;
    logic err, done;
    logic [3:0]  got_wea, exp_wea;
    logic [31:0] got_addra, got_dina, exp_dina, exp_rd;
    n = nbytes(sz);
    err = (sz == 2'b11) || ((a % n) != 0) || (a >= MEM_BYTES);
    exp_lat = err ? 1 : (we ? 2 : 3);
    got_wea = 4'b0; got_addra = 32'd0; got_dina = 32'd0;
    @(negedge clk);
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    check("ready_idle", {31'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; wcnt = 0; done = 1'b0;
    for (int c = 1; c <= 8 && !done; c++) begin
      @(negedge clk);
      if (c == 1) check("ready_busy", {31'd0, req_ready}, 32'd0);
      if (mem_wea != 4'b0) begin
        wcnt++; got_wea = mem_wea; got_addra = mem_addra; got_dina = mem_dina;
      end
      if (resp_valid) begin lat = c; done = 1'b1; end
    end
    check("resp_seen", {31'd0, done}, 32'd1);
    check("latency", lat, exp_lat);
    check("resp_err", {31'd0, resp_err}, {31'd0, err});
    if (err) begin
      check("err_nowrite", wcnt, 0);
      check("err_rdata_hold", resp_rdata, last_rdata);
    end else if (we) begin
      exp_wea = 4'b0;
      for (int i = 0; i < n; i++) exp_wea[a[1:0] + i] = 1'b1;
      for (int k = 0; k < 4; k++) exp_dina[8*k +: 8] = wd[8*(k % n) +: 8];
      check("st_wcnt", wcnt, 1);
      check("st_wea", {28'd0, got_wea}, {28'd0, exp_wea});
      check("st_addra", got_addra, a >> 2);
      check("st_dina", got_dina, exp_dina);
      check("st_rdata_hold", resp_rdata, last_rdata);
      for (int i = 0; i < n; i++) ref_mem[a + i] = wd[8*i +: 8];
    end else begin
      exp_rd = ref_load(a, sz, sg);
      check("ld_nowrite", wcnt, 0);
      check("ld_rdata", resp_rdata, exp_rd);
      last_rdata = exp_rd;
    end
    @(negedge clk);
    check("resp_pulse", {31'd0, resp_valid}, 32'd0);
    check("ready_after", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    int acc, resps, seen;
    int acc_cyc [3];
    logic [31:0] b2b_addr [3];
    logic [1:0]  b2b_size [3];
    logic        b2b_sg [3];
    logic [31:0] b2b_exp [3];
    logic [1:0]  sz;
    logic [31:0] a;

    for (int i = 0; i < (1 << AW); i++) ram[i] = 32'd0;
    for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'd0;
    last_rdata = 32'd0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst_ready", {31'd0, req_ready}, 32'd1);
    check("rst_rvalid", {31'd0, resp_valid}, 32'd0);
    check("rst_rerr", {31'd0, resp_err}, 32'd0);
    check("rst_rdata", resp_rdata, 32'd0);
    check("rst_wea", {28'd0, mem_wea}, 32'd0);
    check("rst_addra", mem_addra, 32'd0);
    check("rst_dina", mem_dina, 32'd0);

    // Directed scenarios
    do_req(1'b1, 2'b10, 1'b0, 32'h0, 32'h0000_000D);
    do_req(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    check("tp_ld0", resp_rdata, 32'h0000_000D);
    do_req(1'b1, 2'b10, 1'b0, 32'h4, 32'h8877_6655);
    do_req(1'b1, 2'b00, 1'b0, 32'h6, 32'h0000_00AB);
    do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
    check("tp_ld4", resp_rdata, 32'h88AB_6655);
    do_req(1'b0, 2'b00, 1'b1, 32'h7, 32'h0);
    check("tp_lsb7", resp_rdata, 32'hFFFF_FF88);
    do_req(1'b0, 2'b00, 1'b0, 32'h7, 32'h0);
    check("tp_lub7", resp_rdata, 32'h0000_0088);
    do_req(1'b0, 2'b01, 1'b1, 32'h6, 32'h0);
    check("tp_lsh6", resp_rdata, 32'hFFFF_88AB);
    do_req(1'b0, 2'b10, 1'b0, 32'h2, 32'h0);
    do_req(1'b1, 2'b11, 1'b0, 32'h8, 32'h1234_5678);
    do_req(1'b0, 2'b10, 1'b0, 32'h0000_1000, 32'h0);
    do_req(1'b1, 2'b01, 1'b0, 32'h3FE, 32'hCAFE_BEEF);
    do_req(1'b0, 2'b01, 1'b0, 32'h3FE, 32'h0);

    // Back-to-back loads with req_valid held high
    b2b_addr[0] = 32'h0; b2b_size[0] = 2'b10; b2b_sg[0] = 1'b0;
    b2b_addr[1] = 32'h7; b2b_size[1] = 2'b00; b2b_sg[1] = 1'b1;
    b2b_addr[2] = 32'h4; b2b_size[2] = 2'b01; b2b_sg[2] = 1'b0;
    for (int i = 0; i < 3; i++) b2b_exp[i] = ref_load(b2b_addr[i], b2b_size[i], b2b_sg[i]);
    acc = 0; resps = 0;
    for (int i = 0; i < 3; i++) acc_cyc[i] = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      if (resp_valid) begin
        if (resps < 3) check("b2b_rdata", resp_rdata, b2b_exp[resps]);
        resps++;
      end
      if (req_ready) begin
        if (acc < 3) begin
          req_we = 1'b0; req_addr = b2b_addr[acc]; req_size = b2b_size[acc];
          req_signed = b2b_sg[acc]; req_valid = 1'b1;
          acc_cyc[acc] = cyc;
          acc++;
        end else begin
          req_valid = 1'b0;
        end
      end
    end
    req_valid = 1'b0;
    check("b2b_acc", acc, 3);
    check("b2b_gap1", acc_cyc[1] - acc_cyc[0], 4);
    check("b2b_gap2", acc_cyc[2] - acc_cyc[1], 4);
    check("b2b_resps", resps, 3);
    last_rdata = b2b_exp[2];

    // Reset during RD1 of a load
    @(negedge clk);
    req_we = 1'b0; req_size = 2'b10; req_addr = 32'h4; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mrst_ready", {31'd0, req_ready}, 32'd1);
    check("mrst_rvalid", {31'd0, resp_valid}, 32'd0);
    check("mrst_rdata", resp_rdata, 32'd0);
    last_rdata = 32'd0;
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    check("mrst_noresp", seen, 0);
    do_req(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);

    // Reset wins over a simultaneous request
    @(negedge clk);
    rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h0;
    @(negedge clk);
    rst = 1'b0; req_valid = 1'b0;
    check("rstreq_ready", {31'd0, req_ready}, 32'd1);
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    check("rstreq_noresp", seen, 0);
    last_rdata = 32'd0;

    // Randomized traffic
    for (int t = 0; t < 80; t++) begin
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = $urandom;
      else a = $urandom_range(0, MEM_BYTES - 1);
      if ($urandom_range(0, 3) != 0) a = a & ~(32'(nbytes(sz)) - 32'd1);
      do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
